// File: rtl/benes_route_cfg_loader.sv
// benes_route_cfg_loader: collects Benes switch-select words into a shadow bank and commits
// them atomically to the active bank once the network pipeline has drained.
module benes_route_cfg_loader #(
    parameter int STAGE_NUM     = 9,
    parameter int SWITCH_NUM    = 16,
    parameter int COMMAND_WIDTH = 8,
    parameter int FSIZE         = 64,
    parameter int CMD_LOAD      = 100,
    parameter int CMD_COMMIT    = 101,
    parameter int CMD_CLEAR     = 102
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_cmd_valid,
    input  logic [COMMAND_WIDTH-1:0]        i_cmd_command,
    input  logic [FSIZE-1:0]                i_cmd_data0,
    input  logic [FSIZE-1:0]                i_cmd_data1,
    output logic                            o_cmd_ready,
    input  logic                            i_net_idle,
    output logic [STAGE_NUM*SWITCH_NUM-1:0] o_module_select,
    output logic [STAGE_NUM*SWITCH_NUM-1:0] o_slot_select,
    output logic                            o_commit_done,
    output logic                            o_cfg_error,
    output logic                            o_shadow_full
);
    typedef enum logic {IDLE, WAIT_IDLE} state_t;
    state_t state_q, state_d;
    logic [SWITCH_NUM-1:0] sh_q [2][STAGE_NUM];
    logic [SWITCH_NUM-1:0] sh_d [2][STAGE_NUM];
    logic [SWITCH_NUM-1:0] act_q [2][STAGE_NUM];
    logic [SWITCH_NUM-1:0] act_d [2][STAGE_NUM];
    logic [1:0][STAGE_NUM-1:0] mask_q, mask_d;
    logic ready_q, ready_d, done_q, done_d, err_q, err_d, full_q, full_d;
    logic [3:0] idx;
    logic net, accept, unused_bits;
    assign idx = i_cmd_data0[3:0];
    assign net = i_cmd_data0[4];
    assign accept = i_cmd_valid & ready_q;
    assign unused_bits = ^{i_cmd_data0[FSIZE-1:5], i_cmd_data1[FSIZE-1:SWITCH_NUM]};
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        act_d   = act_q;
        mask_d  = mask_q;
        err_d   = err_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (accept && i_cmd_command == COMMAND_WIDTH'(CMD_LOAD)) begin
                if (idx < 4'(STAGE_NUM)) begin
                    sh_d[net][idx]   = i_cmd_data1[SWITCH_NUM-1:0];
                    mask_d[net][idx] = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end else if (accept && i_cmd_command == COMMAND_WIDTH'(CMD_COMMIT)) begin
                state_d = full_q ? WAIT_IDLE : IDLE;
                err_d   = err_q | ~full_q;
            end else if (accept && i_cmd_command == COMMAND_WIDTH'(CMD_CLEAR)) begin
                sh_d   = '{default: '0};
                mask_d = '0;
                err_d  = 1'b0;
            end
        end else if (i_net_idle) begin
            // shadow is kept so a later commit can reuse it once every word is rewritten
            act_d   = sh_q;
            mask_d  = '0;
            done_d  = 1'b1;
            state_d = IDLE;
        end
        ready_d = state_d == IDLE;
        full_d  = &mask_d;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sh_q    <= '{default: '0};
            act_q   <= '{default: '0};
            mask_q  <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            act_q   <= act_d;
            mask_q  <= mask_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            err_q   <= err_d;
            full_q  <= full_d;
        end
    end
    for (genvar s = 0; s < STAGE_NUM; s++) begin : g_out
        assign o_module_select[s*SWITCH_NUM +: SWITCH_NUM] = act_q[0][s];
        assign o_slot_select[s*SWITCH_NUM +: SWITCH_NUM]   = act_q[1][s];
    end
    assign o_cmd_ready   = ready_q;
    assign o_commit_done = done_q;
    assign o_cfg_error   = err_q;
    assign o_shadow_full = full_q;
endmodule

// File: tb/tb_benes_route_cfg_loader.sv
// tb_benes_route_cfg_loader: directed and random command streams checked every cycle against
// an array-based model of the shadow/active banks and the commit handshake.
module tb_benes_route_cfg_loader;
    localparam int SN = 9;
    localparam int SW = 16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cmd_valid = 1'b0;
    logic [7:0] cmd = '0;
    logic [63:0] d0 = '0;
    logic [63:0] d1 = '0;
    logic net_idle = 1'b0;
    logic cmd_ready, commit_done, cfg_error, shadow_full;
    logic [SN*SW-1:0] module_select, slot_select;
    int errors = 0;
    int checks = 0;
    logic [15:0] m_sh [2][SN];
    logic [15:0] m_act [2][SN];
    bit m_wr [2][SN];
    bit m_err, m_wait, m_ready, m_done;

    benes_route_cfg_loader dut (
        .clk(clk), .rst(rst), .i_cmd_valid(cmd_valid), .i_cmd_command(cmd),
        .i_cmd_data0(d0), .i_cmd_data1(d1), .o_cmd_ready(cmd_ready), .i_net_idle(net_idle),
        .o_module_select(module_select), .o_slot_select(slot_select),
        .o_commit_done(commit_done), .o_cfg_error(cfg_error), .o_shadow_full(shadow_full)
    );

    always #5 clk = ~clk;

    function automatic bit m_full();
        int n = 0;
        for (int k = 0; k < 2; k++)
            for (int s = 0; s < SN; s++) n += int'(m_wr[k][s]);
        return n == 2 * SN;
    endfunction

    task automatic model_edge();
        int idx = int'(d0[3:0]);
        int net = int'(d0[4]);
        if (rst) begin
            foreach (m_sh[k, s]) begin m_sh[k][s] = '0; m_act[k][s] = '0; m_wr[k][s] = 0; end
            m_err = 0; m_wait = 0; m_ready = 0; m_done = 0;
        end else if (m_wait) begin
            m_done = net_idle;
            if (net_idle) begin
                foreach (m_sh[k, s]) begin m_act[k][s] = m_sh[k][s]; m_wr[k][s] = 0; end
                m_wait = 0;
            end
            m_ready = !m_wait;
        end else begin
            m_done = 0;
            if (cmd_valid && m_ready) begin
                if (cmd == 8'd100 && idx < SN) begin
                    m_sh[net][idx] = d1[15:0];
                    m_wr[net][idx] = 1;
                end else if (cmd == 8'd100) m_err = 1;
                else if (cmd == 8'd101 && m_full()) m_wait = 1;
                else if (cmd == 8'd101) m_err = 1;
                else if (cmd == 8'd102) begin
                    foreach (m_sh[k, s]) begin m_sh[k][s] = '0; m_wr[k][s] = 0; end
                    m_err = 0;
                end
            end
            m_ready = !m_wait;
        end
    endtask

    task automatic check_all(input string tag);
        logic [SN*SW-1:0] em, es;
        for (int s = 0; s < SN; s++) begin
            em[s*SW +: SW] = m_act[0][s];
            es[s*SW +: SW] = m_act[1][s];
        end
        checks++;
        assert (module_select === em) else begin errors++; $error("FAIL %s module_select got=%h exp=%h", tag, module_select, em); end
        checks++;
        assert (slot_select === es) else begin errors++; $error("FAIL %s slot_select got=%h exp=%h", tag, slot_select, es); end
        checks++;
        assert (cmd_ready === m_ready) else begin errors++; $error("FAIL %s ready got=%b exp=%b", tag, cmd_ready, m_ready); end
        checks++;
        assert (commit_done === m_done) else begin errors++; $error("FAIL %s commit_done got=%b exp=%b", tag, commit_done, m_done); end
        checks++;
        assert (cfg_error === m_err) else begin errors++; $error("FAIL %s cfg_error got=%b exp=%b", tag, cfg_error, m_err); end
        checks++;
        assert (shadow_full === m_full()) else begin errors++; $error("FAIL %s shadow_full got=%b exp=%b", tag, shadow_full, m_full()); end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic do_cmd(input int c, input int idx, input int net, input logic [15:0] w, input string tag);
        cmd_valid = 1'b1;
        cmd = 8'(c);
        d0 = ({$urandom, $urandom} & ~64'h1F) | 64'(idx & 15) | (64'(net & 1) << 4);
        d1 = {$urandom, $urandom, w};
        tick(tag);
        cmd_valid = 1'b0;
    endtask

    task automatic load_all(input int skip);
        for (int s = 0; s < SN; s++) begin
            do_cmd(100, s, 0, 16'h0001 << s, "load_mod");
            if (s != skip) do_cmd(100, s, 1, 16'hFFFF >> s, "load_slot");
        end
    endtask

    task automatic expect_bit(input logic got, input logic exp, input string tag);
        checks++;
        assert (got === exp) else begin errors++; $error("FAIL %s got=%b exp=%b", tag, got, exp); end
    endtask

    initial begin
        @(negedge clk);
        rst = 1'b1;
        tick("reset0"); tick("reset1"); tick("reset2");
        rst = 1'b0;
        tick("post_reset");
        expect_bit(cmd_ready, 1'b1, "ready_after_reset");

        net_idle = 1'b1;
        load_all(-1);
        expect_bit(shadow_full, 1'b1, "full_after_18");
        do_cmd(101, 0, 0, '0, "commit");
        expect_bit(cmd_ready, 1'b0, "ready_in_wait");
        tick("commit_upd");
        checks++;
        assert (module_select[4*SW +: SW] === 16'h0010 && slot_select[3*SW +: SW] === 16'h1FFF)
            else begin errors++; $error("FAIL commit_words got=%h/%h exp=0010/1fff", module_select[4*SW +: SW], slot_select[3*SW +: SW]); end
        expect_bit(commit_done, 1'b1, "done_pulse");
        tick("done_drop");

        load_all(-1);
        net_idle = 1'b0;
        do_cmd(101, 0, 0, '0, "def_commit");
        do_cmd(100, 0, 0, 16'h1234, "load_in_wait");
        repeat (4) tick("def_wait");
        net_idle = 1'b1;
        tick("def_upd");
        tick("def_after");

        do_cmd(100, 9, 0, 16'hBEEF, "bad_stage");
        load_all(8);
        do_cmd(101, 0, 0, '0, "commit_17");
        do_cmd(102, 0, 0, '0, "clear");
        expect_bit(cfg_error, 1'b0, "err_cleared");

        load_all(-1);
        do_cmd(100, 4, 0, 16'hAAAA, "ow1");
        do_cmd(41, 4, 0, 16'h7777, "foreign1");
        do_cmd(100, 4, 0, 16'h5555, "ow2");
        do_cmd(41, 2, 1, 16'h0F0F, "foreign2");
        do_cmd(101, 0, 0, '0, "ow_commit");
        tick("ow_upd");
        checks++;
        assert (module_select[4*SW +: SW] === 16'h5555)
            else begin errors++; $error("FAIL overwrite got=%h exp=5555", module_select[4*SW +: SW]); end

        load_all(-1);
        net_idle = 1'b0;
        do_cmd(101, 0, 0, '0, "abort_commit");
        tick("abort_wait");
        rst = 1'b1;
        tick("abort_rst");
        rst = 1'b0;
        net_idle = 1'b1;
        tick("abort_after");
        tick("abort_after2");
        expect_bit(commit_done, 1'b0, "abort_no_done");

        for (int i = 0; i < 400; i++) begin
            int r = $urandom_range(0, 99);
            net_idle = ($urandom_range(0, 2) != 0);
            rst = ($urandom_range(0, 199) == 0);
            if (r < 75) do_cmd(100, $urandom_range(0, 10), $urandom_range(0, 1), 16'($urandom), "rnd_load");
            else if (r < 85) do_cmd(101, 0, 0, '0, "rnd_commit");
            else if (r < 88) do_cmd(102, 0, 0, '0, "rnd_clear");
            else if (r < 94) do_cmd($urandom_range(0, 99), $urandom_range(0, 15), 0, 16'($urandom), "rnd_foreign");
            else tick("rnd_idle");
        end
        rst = 1'b0;
        tick("final");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
